// File: rtl/act_pkg.sv
// Shared types and constants for the activation-unit arbiter.
// FSM encodings, in-flight tag layout and statistics helpers.
package act_pkg;

  localparam int DATA_W_DEF = 20;
  localparam int ID_W       = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [2:0] STAT_SEL_BUSY = 3'd7;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/act_unit_arbiter_rr.sv
// Combinational round-robin picker for the activation arbiter.
// Searches cyclically from ptr; the pointer register lives in the parent.
module rr_arbiter
  import act_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  localparam int IW1 = IW + 1;

  logic [IW:0] pos;

  // first eligible requester at or after ptr, wrapping at N
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + IW1'(k);
      if (pos >= IW1'(N)) begin
        pos = pos - IW1'(N);
      end
      if (!grant_any && eligible[pos[IW-1:0]]) begin
        grant_any            = 1'b1;
        grant[pos[IW-1:0]]   = 1'b1;
        grant_idx            = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/act_unit_arbiter.sv
// Round-robin sequencer sharing one fixed-latency activation unit.
// Optional statistics counters: define ACT_ARB_STATS_EN.
module act_unit_arbiter
  import act_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [N_REQ*DATA_W-1:0] rsp_data,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic                    unit_in_valid,
  output logic [DATA_W-1:0]       unit_in_data,
  input  logic                    unit_out_valid,
  input  logic [DATA_W-1:0]       unit_out_data,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    err,
  output logic [15:0]             stat_cnt,
  input  logic [2:0]              stat_sel
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     next_ptr;
  tag_t              tag_q [LAT+1];
  tag_t              tag_end;
  logic              tags_empty;
  logic              drain_done;
  logic [N_REQ-1:0]  inflight;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_any;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_q   [N_REQ];
  logic [DATA_W-1:0] req_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_pack
    assign req_arr[i] = req_data[i*DATA_W +: DATA_W];
    assign rsp_data[i*DATA_W +: DATA_W] = rsp_q[i];
  end

  assign tag_end   = tag_q[LAT];
  assign rsp_valid = rsp_valid_q;
  assign req_ready = grant;

  // requesters with a tag anywhere in the pipeline are busy
  always_comb begin
    inflight   = '0;
    tags_empty = 1'b1;
    for (int s = 0; s <= LAT; s++) begin
      if (tag_q[s].valid) begin
        tags_empty = 1'b0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_q[s].valid && tag_q[s].id == ID_W'(i)) begin
          inflight[i] = 1'b1;
        end
      end
    end
  end

  assign eligible = req_valid & ~inflight & ~rsp_valid_q
                  & {N_REQ{state_q == ST_RUN}};

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign next_ptr = (grant_idx == IW'(N_REQ - 1))
                  ? '0 : grant_idx + IW'(1);

  assign drain_done = (state_q == ST_DRAIN) && tags_empty;

  // run/drain sequencing; IDLE is held while flush stays high
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid && !flush_req) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_DRAIN;
        end else if (tags_empty && !(|req_valid)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (tags_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, pointer, unit issue register and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr        <= '0;
      flush_done    <= 1'b0;
      unit_in_valid <= 1'b0;
      unit_in_data  <= '0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_done    <= drain_done;
      unit_in_valid <= grant_any;
      if (grant_any) begin
        unit_in_data <= req_arr[grant_idx];
        rr_ptr       <= next_ptr;
      end
      // only a missing result is flagged; strays are dropped
      if (tag_end.valid && !unit_out_valid) begin
        err <= 1'b1;
      end
    end
  end

  // tag shift register aligned with the unit latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0].valid <= grant_any;
      tag_q[0].id    <= ID_W'(grant_idx);
      for (int s = 1; s <= LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // capture tagged results and hold until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_end.valid && unit_out_valid
            && tag_end.id == ID_W'(i)) begin
          rsp_q[i]       <= unit_out_data;
          rsp_valid_q[i] <= 1'b1;
        end else if (rsp_valid_q[i] && rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef ACT_ARB_STATS_EN
  logic [15:0] gcnt [N_REQ];
  logic [15:0] busy_cnt;
  logic [15:0] stat_q;

  // saturating grant and busy counters, cleared by a finished flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        gcnt[i] <= '0;
      end
    end else if (flush_done) begin
      busy_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        gcnt[i] <= '0;
      end
    end else begin
      if (unit_in_valid) begin
        busy_cnt <= sat_inc(busy_cnt);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          gcnt[i] <= sat_inc(gcnt[i]);
        end
      end
    end
  end

  // registered readout mux
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else if (flush_done) begin
      stat_q <= '0;
    end else if (stat_sel == STAT_SEL_BUSY) begin
      stat_q <= busy_cnt;
    end else if (int'(stat_sel) < N_REQ) begin
      stat_q <= gcnt[stat_sel[IW-1:0]];
    end else begin
      stat_q <= '0;
    end
  end

  assign stat_cnt = stat_q;
`else
  logic unused_stat;
  assign unused_stat = ^stat_sel;
  assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_act_unit_arbiter.sv
// Scoreboard bench for act_unit_arbiter with a behavioural unit.
// Directed vectors; expected results hand-computed.
module tb_act_unit_arbiter;

  localparam int N   = 4;
  localparam int DW  = 20;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [N-1:0]    rsp_ready;
  logic            unit_in_valid;
  logic [DW-1:0]   unit_in_data;
  logic            unit_out_valid;
  logic [DW-1:0]   unit_out_data;
  logic            flush_req;
  logic            flush_done;
  logic            err;
  logic [15:0]     stat_cnt;
  logic [2:0]      stat_sel;

  act_unit_arbiter #(
    .N_REQ  (N),
    .DATA_W (DW),
    .LAT    (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_ready      (rsp_ready),
    .unit_in_valid  (unit_in_valid),
    .unit_in_data   (unit_in_data),
    .unit_out_valid (unit_out_valid),
    .unit_out_data  (unit_out_data),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .err            (err),
    .stat_cnt       (stat_cnt),
    .stat_sel       (stat_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural shared unit: fixed latency, output = input ^ 0x00310
  logic [LAT-1:0] pv;
  logic [DW-1:0]  pd0, pd1, pd2;
  logic           unit_clr;
  logic           suppress;
  logic           stray;

  always @(posedge clk) begin
    if (unit_clr) pv <= '0;
    else pv <= {pv[LAT-2:0], unit_in_valid};
    pd0 <= unit_in_data ^ 20'h00310;
    pd1 <= pd0;
    pd2 <= pd1;
  end

  assign unit_out_valid = (pv[LAT-1] & ~suppress) | stray;
  assign unit_out_data  = pd2;

  logic [DW-1:0] exp_q [N][$];
  int rsp_cnt [N];
  int gq_id [$];
  int gq_cyc [$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // monitor: grant log and response scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (|req_ready)
          chk("ready_onehot", $onehot(req_ready), 1);
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            gq_id.push_back(i);
            gq_cyc.push_back(cyc);
          end
          if (rsp_valid[i] && rsp_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rsp_unexpected_%0d: got %0h expected none",
                       i, rsp_data[i*DW +: DW]);
            end else begin
              chk($sformatf("rsp_data_%0d", i),
                  rsp_data[i*DW +: DW], exp_q[i].pop_front());
            end
            rsp_cnt[i]++;
          end
        end
      end
    end
  end

  task automatic issue(input int i, input logic [DW-1:0] d,
                       input logic [DW-1:0] e, input bit track,
                       output int gc);
    int n;
    gc = -1;
    req_data[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (req_ready[i]) break;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout_%0d: got no grant expected grant", i);
      req_valid[i] = 1'b0;
    end else begin
      gc = cyc;
      if (track) exp_q[i].push_back(e);
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  int g0, g1, g2, g3, gc, n, c0, c1, c3;
  bit stable, nogrant, e_bad, r_bad;
  logic [DW-1:0] held;
  logic [DW-1:0] sd [5] = '{20'h00010, 20'h00001, 20'hFFFFF,
                            20'h80000, 20'h12345};
  logic [DW-1:0] se [5] = '{20'h00300, 20'h00311, 20'hFFCEF,
                            20'h80310, 20'h12055};
  int exp_ids [5] = '{0, 1, 2, 3, 0};
  int exp_off [5] = '{0, 1, 2, 3, 6};

  initial begin
    rst = 1'b1;
    unit_clr = 1'b1;
    suppress = 1'b0;
    stray = 1'b0;
    req_valid = '0;
    req_data = '0;
    rsp_ready = '1;
    flush_req = 1'b0;
    stat_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1 unit_clr = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data[31:0], 0);
    chk("rst_rsp_data_hi", rsp_data[79:32], 0);
    chk("rst_in_valid", unit_in_valid, 0);
    chk("rst_in_data", unit_in_data, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_err", err, 0);
    chk("rst_stat", stat_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single request latency
    issue(1, 20'h00010, 20'h00300, 1'b1, gc);
    @(negedge clk);
    chk("t1_in_valid", unit_in_valid, 1);
    chk("t1_in_data", unit_in_data, 20'h00010);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_latency", cyc - gc, 5);
    chk("t1_rsp_data", rsp_data[1*DW +: DW], 20'h00300);

    // all four from reset, then re-request by 0
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    gq_id.delete();
    gq_cyc.delete();
    fork
      begin
        issue(0, 20'h00001, 20'h00311, 1'b1, g0);
        issue(0, 20'h00310, 20'h00000, 1'b1, g0);
      end
      issue(1, 20'hFFFFF, 20'hFFCEF, 1'b1, g1);
      issue(2, 20'h7FFFF, 20'h7FCEF, 1'b1, g2);
      issue(3, 20'h80000, 20'h80310, 1'b1, g3);
    join
    chk("rr_count", gq_id.size(), 5);
    if (gq_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_id_%0d", k), gq_id[k], exp_ids[k]);
        chk($sformatf("rr_cyc_%0d", k),
            gq_cyc[k] - gq_cyc[0], exp_off[k]);
      end
    end

    // backpressure on requester 2
    repeat (10) @(posedge clk);
    #1 rsp_ready[2] = 1'b0;
    issue(2, 20'h12345, 20'h12055, 1'b1, g2);
    n = 0;
    while (!rsp_valid[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    held = rsp_data[2*DW +: DW];
    chk("bp_held", held, 20'h12055);
    c0 = rsp_cnt[0];
    c3 = rsp_cnt[3];
    stable = 1'b1;
    nogrant = 1'b1;
    @(posedge clk);
    #1;
    fork
      issue(2, 20'h55555, 20'h55645, 1'b1, g2);
      issue(0, 20'hABCDE, 20'hABFCE, 1'b1, g0);
      issue(3, 20'h00010, 20'h00300, 1'b1, g3);
      begin
        repeat (12) begin
          @(negedge clk);
          if (rsp_data[2*DW +: DW] !== held) stable = 1'b0;
          if (req_ready[2] || !rsp_valid[2]) nogrant = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_no_grant", nogrant, 1);
        chk("bp_other_0", rsp_cnt[0] - c0, 1);
        chk("bp_other_3", rsp_cnt[3] - c3, 1);
        @(posedge clk);
        #1 rsp_ready[2] = 1'b1;
      end
    join

    // flush with three ops in flight
    repeat (10) @(posedge clk);
    #1;
    c0 = rsp_cnt[0];
    c1 = rsp_cnt[1];
    c3 = rsp_cnt[3];
    fork
      issue(0, 20'h00311, 20'h00001, 1'b1, g0);
      issue(1, 20'h12345, 20'h12055, 1'b1, g1);
      issue(3, 20'h55555, 20'h55645, 1'b1, g3);
    join
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    req_data[2*DW +: DW] = 20'hFFFFF;
    req_valid[2] = 1'b1;
    nogrant = 1'b1;
    n = 0;
    while (n < 40 && !flush_done) begin
      @(negedge clk);
      if (|req_ready) nogrant = 1'b0;
      n++;
    end
    chk("fl_done_seen", flush_done, 1);
    chk("fl_no_grant", nogrant, 1);
    chk("fl_rsp_0", rsp_cnt[0] - c0, 1);
    chk("fl_rsp_1", rsp_cnt[1] - c1, 1);
    chk("fl_rsp_3", rsp_cnt[3] - c3, 1);
    @(negedge clk);
    chk("fl_done_pulse", flush_done, 0);
    chk("fl_idle_hold", req_ready, 0);
    @(posedge clk);
    #1 flush_req = 1'b0;
    issue(2, 20'hFFFFF, 20'hFFCEF, 1'b1, g2);

    // suppressed unit result
    repeat (10) @(posedge clk);
    #1 suppress = 1'b1;
    issue(3, 20'h00001, 20'h00311, 1'b0, g3);
    repeat (8) @(negedge clk);
    chk("miss_err", err, 1);
    chk("miss_no_rsp", rsp_valid[3], 0);
    @(posedge clk);
    #1 suppress = 1'b0;
    repeat (5) @(negedge clk);
    chk("miss_err_sticky", err, 1);

    // reset mid-flight, then stray unit results
    @(posedge clk);
    #1;
    fork
      issue(0, 20'h00010, 20'h00300, 1'b0, g0);
      issue(1, 20'h00001, 20'h00311, 1'b0, g1);
    join
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_in_valid", unit_in_valid, 0);
    chk("mid_rst_in_data", unit_in_data, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    e_bad = 1'b0;
    r_bad = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 stray = 1'b1;
        repeat (2) @(posedge clk);
        #1 stray = 1'b0;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (err) e_bad = 1'b1;
          if (|rsp_valid) r_bad = 1'b1;
        end
      end
    join
    chk("stray_err", e_bad, 0);
    chk("stray_rsp", r_bad, 0);

    // five grants to requester 3 for statistics
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      issue(3, sd[k], se[k], 1'b1, g3);
    end
    repeat (10) @(posedge clk);
    #1 stat_sel = 3'd3;
    @(posedge clk);
    @(negedge clk);
`ifdef ACT_ARB_STATS_EN
    chk("stat_grant_3", stat_cnt, 5);
`else
    chk("stat_off_3", stat_cnt, 0);
`endif
    @(posedge clk);
    #1 stat_sel = 3'd7;
    @(posedge clk);
    @(negedge clk);
`ifdef ACT_ARB_STATS_EN
    chk("stat_busy", stat_cnt, 5);
`else
    chk("stat_off_busy", stat_cnt, 0);
`endif
    @(posedge clk);
    #1 stat_sel = 3'd5;
    @(posedge clk);
    @(negedge clk);
    chk("stat_unused_sel", stat_cnt, 0);

    repeat (10) @(posedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("sb_empty_%0d", i), exp_q[i].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
